// File: rtl/cmp_share_arbiter.sv
// -----------------------------------------------------------------------------
// cmp_share_arbiter
//
// Shares a single comparator between two execute-stage requesters:
//   requester 0 = branch resolution, requester 1 = SLT/SLTU writeback.
// Round-robin arbitration with valid/ready handshakes on both the request and
// the response side. The compare result is registered on the grant edge and
// held until the owning requester accepts it, so at most one compare is in
// flight and peak throughput is one compare every two cycles.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   reqN_valid / reqN_ready  request handshake for requester N (ready is
//                            combinational on valid while IDLE)
//   reqN_a, reqN_b           operands for requester N (DATA_W bits)
//   reqN_op                  compare op: NO=0 EQ=1 NE=2 LT=3 GE=4 LTU=5 GEU=6
//                            CMP7=7 (LT/GE signed, LTU/GEU unsigned)
//   rspN_valid / rspN_ready  response handshake for requester N
//   rspN_res                 1-bit compare result, forced 0 when rspN_valid=0
//   busy                     high while a result is being held (RESP)
// -----------------------------------------------------------------------------
module cmp_share_arbiter #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp0_res,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic              rsp1_res,
  output logic              busy
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [2:0] OP_EQ  = 3'd1;
  localparam logic [2:0] OP_NE  = 3'd2;
  localparam logic [2:0] OP_LT  = 3'd3;
  localparam logic [2:0] OP_GE  = 3'd4;
  localparam logic [2:0] OP_LTU = 3'd5;
  localparam logic [2:0] OP_GEU = 3'd6;

  // The shared comparator. NO, CMP7 and anything unlisted yield 0.
  function automatic logic cmp_eval(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b,
                                    input logic [2:0]        op);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic                     r;
    sa = a;
    sb = b;
    case (op)
      OP_EQ:   r = (a == b);
      OP_NE:   r = (a != b);
      OP_LT:   r = (sa < sb);
      OP_GE:   r = (sa >= sb);
      OP_LTU:  r = (a < b);
      OP_GEU:  r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t              state;
  logic                owner;
  logic                last_grant;
  logic                res_q;

  logic                gnt_sel;
  logic                gnt_fire;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [2:0]          sel_op;
  logic                cmp_res;
  logic                rsp_take;

  // Grant: a lone requester always wins; on contention the one that did not
  // win last time wins. Held off during reset so ready is 0 while rst is high.
  always_comb begin
    gnt_sel  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    gnt_fire = (state == IDLE) && (req0_valid || req1_valid) && !rst;
  end

  assign req0_ready = gnt_fire && !gnt_sel;
  assign req1_ready = gnt_fire &&  gnt_sel;

  // Operand mux in front of the single comparator, steered by the live grant.
  assign sel_a   = gnt_sel ? req1_a  : req0_a;
  assign sel_b   = gnt_sel ? req1_b  : req0_b;
  assign sel_op  = gnt_sel ? req1_op : req0_op;
  assign cmp_res = cmp_eval(sel_a, sel_b, sel_op);

  assign rsp_take = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      res_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_fire) begin
            owner      <= gnt_sel;
            last_grant <= gnt_sel;
            res_q      <= cmp_res;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_take) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response side decodes straight from registered state.
  assign busy       = (state == RESP);
  assign rsp0_valid = busy && !owner;
  assign rsp1_valid = busy &&  owner;
  assign rsp0_res   = rsp0_valid && res_q;
  assign rsp1_res   = rsp1_valid && res_q;

endmodule
